// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester handshakes plus the memory-side bus.
// slave: the arbiter's view; master: the clients and memory driving it.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_write, mem_addr, mem_data_in
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_write, mem_addr, mem_data_in
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright; on a tie the
// port equal to prio wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       winner,
  output logic       any
);

  // Tie goes to prio, otherwise whichever port is asking.
  always_comb begin
    any    = |req;
    winner = (req == 2'b11) ? prio : req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between two requesters.
// One access in flight; grants, read-valid and memory drive are registered.
//
//  state  | meaning
//  IDLE   | sample requests, latch winner's fields onto the memory bus
//  ACCESS | grant pulse to owner; memory write happens at end of cycle
//  RDWAIT | read latency countdown; capture data when cnt reaches zero
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  // Countdown start value; READ_LAT of zero never enters RDWAIT.
  localparam logic [1:0] CNT_INIT = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

  state_t state, next_state;

  logic              owner;
  logic              prio;
  logic              we_q;
  logic [1:0]        cnt;
  logic              gnt0_q, gnt1_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_in_q;

  logic              winner;
  logic              any_req;
  logic              latch_en;
  logic              capture_en;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_pick2 u_pick (
    .req    ({bus.req1, bus.req0}),
    .prio   (prio),
    .winner (winner),
    .any    (any_req)
  );

  // Select the winning requester's fields for latching.
  always_comb begin
    win_we    = winner ? bus.we1    : bus.we0;
    win_addr  = winner ? bus.addr1  : bus.addr0;
    win_wdata = winner ? bus.wdata1 : bus.wdata0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    next_state = state;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          latch_en   = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          next_state = IDLE;
        end else if (READ_LAT == 0) begin
          capture_en = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = RDWAIT;
        end
      end
      RDWAIT: begin
        if (cnt == 2'd0) begin
          capture_en = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch request fields, pulse grant/valid, count read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner         <= 1'b0;
      prio          <= 1'b0;
      we_q          <= 1'b0;
      cnt           <= 2'd0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
    end else begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      mem_write_q <= 1'b0;

      if (latch_en) begin
        owner         <= winner;
        prio          <= ~winner;
        we_q          <= win_we;
        mem_write_q   <= win_we;
        mem_addr_q    <= win_addr;
        mem_data_in_q <= win_wdata;
        gnt0_q        <= ~winner;
        gnt1_q        <= winner;
      end

      if (state == ACCESS && !we_q)
        cnt <= CNT_INIT;
      else if (state == RDWAIT && cnt != 2'd0)
        cnt <= cnt - 2'd1;

      if (capture_en) begin
        if (owner) begin
          rdata1_q  <= bus.mem_data_out;
          rvalid1_q <= 1'b1;
        end else begin
          rdata0_q  <= bus.mem_data_out;
          rvalid0_q <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.rvalid0     = rvalid0_q;
  assign bus.rvalid1     = rvalid1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;

endmodule
